// File: rtl/run_detect_fsm.sv
// Multi-channel run-length detector: each channel flags when its w input has
// been high for a programmable number of consecutive enabled edges.
module run_detect_fsm #(
  parameter int CH    = 4,
  parameter int CNT_W = 4,
  parameter int HIT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic             mode_i,
  input  logic [CH-1:0]    w_i,
  output logic [CH-1:0]    z_o,
  output logic [CH-1:0]    pulse_o,
  input  logic             clr_hits_i,
  output logic [HIT_W-1:0] hits_o
);

  typedef enum logic [1:0] {IDLE, RUN, HIT, LOCK} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};
  localparam int SUM_W = HIT_W + $clog2(CH + 1);

  state_e             state_q [CH];
  state_e             state_d [CH];
  logic [CNT_W-1:0]   cnt_q   [CH];
  logic [CNT_W-1:0]   cnt_d   [CH];
  logic [CNT_W-1:0]   cntInc  [CH];
  logic [CH-1:0]      pulse_q, pulse_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic [CNT_W-1:0]   thrEff;
  logic [SUM_W-1:0]   hitSum;

  assign thrEff = (thresh_i == '0) ? CNT_W'(1) : thresh_i;

  // Run length including the current w bit, saturating instead of wrapping.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cntInc[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + CNT_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = 1'b0;
      if (en_i) begin
        cnt_d[i] = w_i[i] ? cntInc[i] : '0;
        case (state_q[i])
          IDLE, RUN: begin
            if (!w_i[i]) begin
              state_d[i] = IDLE;
            end else if (cntInc[i] >= thrEff) begin
              state_d[i] = HIT;
              pulse_d[i] = 1'b1;
            end else begin
              state_d[i] = RUN;
            end
          end
          HIT:     state_d[i] = !w_i[i] ? IDLE : (mode_i ? LOCK : HIT);
          LOCK:    state_d[i] = w_i[i] ? LOCK : IDLE;
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  // Pulses registered on this edge are the ones counted; a clear discards them.
  always_comb begin
    hitSum = SUM_W'(hits_q);
    for (int i = 0; i < CH; i++) begin
      hitSum = hitSum + SUM_W'(pulse_d[i]);
    end
    if (clr_hits_i) begin
      hits_d = '0;
    end else if (hitSum > SUM_W'(HIT_MAX)) begin
      hits_d = HIT_MAX;
    end else begin
      hits_d = hitSum[HIT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pulse_q <= '0;
      hits_q  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pulse_q <= pulse_d;
      hits_q  <= hits_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      z_o[i] = (state_q[i] == HIT);
    end
  end

  assign pulse_o = pulse_q;
  assign hits_o  = hits_q;

endmodule

// File: tb/tb_run_detect_fsm.sv
// Bench for run_detect_fsm: a wide instance and a narrow (CNT_W=2, HIT_W=3)
// instance share stimulus and are both checked against a run-length model.
module tb_run_detect_fsm;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       en = 1'b1;
  logic       mode = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] thresh = 4'd0;
  logic [3:0] w = 4'd0;
  logic [3:0] z1, p1, z2, p2;
  logic [7:0] h1;
  logic [2:0] h2;

  int nChecks = 0;
  int nFails  = 0;

  // Model: run length so far, whether the channel is flagging, whether it has
  // already fired in one-shot mode and must wait for a 0.
  int mCnt   [2][4];
  bit mZ     [2][4];
  bit mLock  [2][4];
  bit mPulse [2][4];
  int mHits  [2];
  int cntMax [2] = '{15, 3};
  int hitMax [2] = '{255, 7};

  int stickyZ [6] = '{0, 0, 1, 1, 1, 0};
  int stickyP [6] = '{0, 0, 1, 0, 0, 0};
  int shotW   [7] = '{1, 1, 1, 1, 0, 1, 1};
  int shotZ   [7] = '{0, 1, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  run_detect_fsm #(.CH(4), .CNT_W(4), .HIT_W(8)) dutWide (
    .clk_i(clk), .reset_ni(rstN), .en_i(en), .thresh_i(thresh), .mode_i(mode),
    .w_i(w), .z_o(z1), .pulse_o(p1), .clr_hits_i(clr), .hits_o(h1)
  );

  run_detect_fsm #(.CH(4), .CNT_W(2), .HIT_W(3)) dutNarrow (
    .clk_i(clk), .reset_ni(rstN), .en_i(en), .thresh_i(thresh[1:0]), .mode_i(mode),
    .w_i(w), .z_o(z2), .pulse_o(p2), .clr_hits_i(clr), .hits_o(h2)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mHits[d] = 0;
      for (int c = 0; c < 4; c++) begin
        mCnt[d][c] = 0; mZ[d][c] = 0; mLock[d][c] = 0; mPulse[d][c] = 0;
      end
    end
  endtask

  task automatic modelStep();
    int t, pc, cntN;
    for (int d = 0; d < 2; d++) begin
      t = (d == 0) ? int'(thresh) : int'(thresh[1:0]);
      if (t == 0) t = 1;
      pc = 0;
      for (int c = 0; c < 4; c++) begin
        mPulse[d][c] = 0;
        if (en) begin
          if (w[c]) begin
            cntN = (mCnt[d][c] + 1 > cntMax[d]) ? cntMax[d] : mCnt[d][c] + 1;
            if (mLock[d][c]) begin
              mZ[d][c] = 0;
            end else if (mZ[d][c]) begin
              if (mode) begin
                mLock[d][c] = 1;
                mZ[d][c] = 0;
              end
            end else if (cntN >= t) begin
              mZ[d][c] = 1;
              mPulse[d][c] = 1;
              pc++;
            end
            mCnt[d][c] = cntN;
          end else begin
            mCnt[d][c] = 0; mZ[d][c] = 0; mLock[d][c] = 0;
          end
        end
      end
      if (clr) mHits[d] = 0;
      else mHits[d] = (mHits[d] + pc > hitMax[d]) ? hitMax[d] : mHits[d] + pc;
    end
  endtask

  task automatic checkAll(input string tag);
    int ez, ep;
    for (int d = 0; d < 2; d++) begin
      ez = 0; ep = 0;
      for (int c = 0; c < 4; c++) begin
        ez |= int'(mZ[d][c]) << c;
        ep |= int'(mPulse[d][c]) << c;
      end
      checkOutput($sformatf("%s z dut%0d", tag, d), (d == 0) ? int'(z1) : int'(z2), ez);
      checkOutput($sformatf("%s pulse dut%0d", tag, d), (d == 0) ? int'(p1) : int'(p2), ep);
      checkOutput($sformatf("%s hits dut%0d", tag, d), (d == 0) ? int'(h1) : int'(h2), mHits[d]);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] wv, input logic env, input logic clrv, input string tag);
    w = wv; en = env; clr = clrv;
    @(posedge clk);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  task automatic doReset();
    w = 4'd0; en = 1'b1; clr = 1'b0;
    rstN = 1'b0;
    modelReset();
    #1;
    checkAll("reset");
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    logic [3:0] wv;
    #1;
    doReset();

    thresh = 4'd3; mode = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus((k < 5) ? 4'b0001 : 4'b0000, 1'b1, 1'b0, "sticky");
      checkOutput($sformatf("sticky z0 edge%0d", k + 1), int'(z1[0]), stickyZ[k]);
      checkOutput($sformatf("sticky pulse0 edge%0d", k + 1), int'(p1[0]), stickyP[k]);
    end
    checkOutput("sticky hits", int'(h1), 1);

    doReset();
    thresh = 4'd2; mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      applyStimulus({2'b00, 1'(shotW[k]), 1'b0}, 1'b1, 1'b0, "oneshot");
      checkOutput($sformatf("oneshot z1 edge%0d", k + 1), int'(z1[1]), shotZ[k]);
      checkOutput($sformatf("oneshot pulse1 edge%0d", k + 1), int'(p1[1]), shotZ[k]);
    end
    checkOutput("oneshot hits", int'(h1), 2);

    doReset();
    thresh = 4'd1; mode = 1'b0;
    applyStimulus(4'hf, 1'b1, 1'b0, "simul");
    checkOutput("simul hits wide", int'(h1), 4);
    checkOutput("simul hits narrow", int'(h2), 4);
    applyStimulus(4'h0, 1'b1, 1'b0, "simul");
    applyStimulus(4'hf, 1'b1, 1'b1, "simulclr");
    checkOutput("simulclr pulse", int'(p1), 15);
    checkOutput("simulclr hits", int'(h1), 0);
    mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'h0, 1'b1, 1'b0, "hitsat");
      applyStimulus(4'hf, 1'b1, 1'b0, "hitsat");
    end
    checkOutput("hitsat narrow", int'(h2), 7);
    checkOutput("hitsat wide", int'(h1), 12);

    doReset();
    thresh = 4'd0; mode = 1'b0;
    applyStimulus(4'b0100, 1'b1, 1'b0, "thresh0");
    checkOutput("thresh0 z", int'(z1), 4);
    checkOutput("thresh0 pulse", int'(p1), 4);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'($urandom), 1'b0, 1'b0, "enoff");
      checkOutput("enoff z hold", int'(z1), 4);
      checkOutput("enoff pulse", int'(p1), 0);
    end
    applyStimulus(4'b0100, 1'b1, 1'b0, "enresume");
    checkOutput("enresume z", int'(z1), 4);
    checkOutput("enresume pulse", int'(p1), 0);

    doReset();
    thresh = 4'd3; mode = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'hf, 1'b1, 1'b0, "cntsat");
      if (k >= 2) checkOutput("cntsat z narrow", int'(z2), 15);
    end
    checkOutput("cntsat hits narrow", int'(h2), 4);
    checkOutput("cntsat hits wide", int'(h1), 4);

    doReset();
    thresh = 4'd2; mode = 1'b0;
    applyStimulus(4'b0001, 1'b1, 1'b0, "prereset");
    applyStimulus(4'b0001, 1'b1, 1'b0, "prereset");
    #3;
    rstN = 1'b0;
    modelReset();
    #1;
    checkOutput("asyncreset z", int'(z1), 0);
    checkOutput("asyncreset pulse", int'(p1), 0);
    checkOutput("asyncreset hits", int'(h1), 0);
    w = 4'd0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b0, "postreset");

    for (int k = 0; k < 400; k++) begin
      thresh = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      for (int c = 0; c < 4; c++) wv[c] = ($urandom_range(0, 3) != 0);
      applyStimulus(wv, $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    nFails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/run_detect_fsm.md
Name: run_detect_fsm

Overview:
Multi-channel, parametrised successor to the single-input w/z sequence-detector FSM. Each channel tracks consecutive 1s on its w input and asserts z once the run length reaches a programmable threshold. It adds a runtime threshold, a sticky or one-shot mode, per-channel hit pulses, a global enable and a saturating aggregate hit counter. It sits between input sampling logic and the event/status block that consumes the pulse and hits outputs.

Parameters:
CH, 4, number of independent detector channels (>=1)
CNT_W, 4, run-length counter width; the counter saturates at 2^CNT_W-1
HIT_W, 8, width of the aggregate hit counter; the counter saturates at 2^HIT_W-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; clears all state immediately when low
en  input  1  global enable; when 0, every channel FSM and counter holds
thresh  input  CNT_W  run length needed for a hit; value 0 is treated as 1
mode  input  1  0 = sticky (z stays high while the run continues); 1 = one-shot (z high one cycle per run)
w  input  CH  per-channel serial input, sampled on each rising edge
z  output  CH  per-channel detect flag, registered (Moore)
pulse  output  CH  per-channel one-cycle strobe on entry to HIT, registered
clr_hits  input  1  synchronous clear of hits
hits  output  HIT_W  saturating count of all pulses across all channels

Behaviour:
- Reset (reset=0, async): every channel goes to IDLE with cnt=0. Outputs z=0, pulse=0, hits=0. Release is synchronous to clk. Reset mid-run discards the run with no pulse.
- Effective threshold: T = (thresh==0) ? 1 : thresh. thresh and mode are sampled every cycle and may change at any time; the new values apply from the next edge.
- Per-channel run counter, on an edge with en=1:
  - cnt_n = w[i] ? min(cnt+1, 2^CNT_W-1) : 0.
  - Saturation must never wrap.
- Per-channel FSM, states IDLE, RUN, HIT, LOCK. All transitions occur only on edges with en=1:
  - IDLE: w=0 -> IDLE. w=1 -> HIT if cnt_n>=T, else RUN.
  - RUN: w=0 -> IDLE. w=1 -> HIT if cnt_n>=T, else RUN.
  - HIT: w=0 -> IDLE. w=1 -> HIT if mode=0, LOCK if mode=1.
  - LOCK: w=0 -> IDLE. w=1 -> LOCK, including if mode changes to 0; a new hit needs a 0 first.
  - Illegal state encoding -> IDLE.
- Outputs:
  - z[i] = (state==HIT).
  - pulse[i] = 1 for exactly the cycle after the edge that enters HIT from IDLE or RUN. HIT->HIT produces no pulse.
- Latency: the w bit that completes the run is sampled at edge k; z and pulse are high after edge k, with zero extra cycles.
  - T=1, mode=1, continuous w=1: pulse once, z for one cycle, then LOCK.
- en=0:
  - state, cnt and z hold.
  - pulse is forced to 0 on that edge.
  - hits still honours clr_hits.
- Lowering thresh below the current cnt during RUN gives HIT on the next edge with w=1 (with a pulse). HIT is never entered on an edge with w=0.
- hits:
  - Each edge, hits_n = min(hits + popcount(pulse_n), 2^HIT_W-1), where pulse_n are the pulses being registered on that edge.
  - Simultaneous pulses on several channels all count.
  - clr_hits=1 has priority: hits_n = 0, and that edge's pulses are not counted.
- Channels are fully independent apart from the shared en, thresh, mode and hits.

Test Plan:
- Reset/async: drive reset=0 mid-clock during a run on ch0 -> z, pulse and hits read 0 before the next edge. After release with w=0, they stay 0.
- Sticky detect: CH=4, thresh=3, mode=0, w[0]=1 for 5 edges then 0.
  - z[0] = 0,0,1,1,1,0.
  - pulse[0] high only after edge 3.
  - hits=1.
- One-shot and re-arm: thresh=2, mode=1, w[1]=1,1,1,1,0,1,1.
  - z[1] high after edges 2 and 7 only.
  - Two pulses; hits=2.
- Simultaneous, clear and saturation:
  - All 4 channels hit on the same edge -> hits += 4.
  - Same scenario with clr_hits=1 on that edge -> hits=0.
  - HIT_W=3 with 9 pulses -> hits holds 7.
- Enable and thresh=0:
  - thresh=0 and w[2]=1 -> HIT after the first edge.
  - Dropping en=0 for 3 edges while w toggles -> z, state and cnt hold, pulse=0.
  - Raising en again -> operation resumes from the held state.
- Counter saturation: CNT_W=2, thresh=3, mode=0, w=1 for 10 edges -> z stays 1, no wrap back to RUN, exactly one pulse.
